ram_buf_sched: RTL and testbench
================================

RAM_BUF_SCHED -- requirements
Module: ram_buf_sched

Interface
REQ-001 Parameter AW, default 4, RAM address width; buffer depth is 2^AW bytes.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  in  1  system clock; all logic sampled on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 clr  in  1  synchronous buffer clear.
REQ-006 rx_rcv  in  1  one-cycle pulse from UART receiver: byte available.
REQ-007 rx_data  in  DW  received byte; valid while rx_rcv=1.
REQ-008 tx_ready  in  1  UART transmitter idle.
REQ-009 tx_start  out  1  one-cycle transmit request.
REQ-010 tx_data  out  DW  byte to transmit; registered.
REQ-011 ram_addr  out  AW  single-port RAM address.
REQ-012 ram_rw  out  1  RAM mode: 1 = read, 0 = write.
REQ-013 ram_wdata  out  DW  RAM write data.
REQ-014 ram_rdata  in  DW  RAM read data; synchronous, valid one cycle after a read address is presented.
REQ-015 count  out  AW+1  bytes stored, 0..2^AW.
REQ-016 full / empty  out  1 each  count==2^AW / count==0.
REQ-017 ovf  out  1  sticky flag: a received byte was lost.

Function
REQ-018 The block SHALL run the RAM as a circular FIFO with wr_ptr and rd_ptr (AW bits each, wrapping 2^AW-1 -> 0) and count.
REQ-019 On rx_rcv, the block SHALL capture rx_data in a one-entry pending register (wr_pend) on the same edge.
REQ-020 FSM states: IDLE, RD_ADDR, RD_DATA, TX_WAIT.
REQ-021 IDLE -> RD_ADDR when !empty && tx_ready && !wr_pend; otherwise stay in IDLE.
REQ-022 RD_ADDR: ram_addr=rd_ptr, ram_rw=1; rd_ptr+1 and count-1 on exit; always -> RD_DATA.
REQ-023 RD_DATA: tx_data<=ram_rdata and tx_start=1 for exactly one cycle; always -> TX_WAIT.
REQ-024 TX_WAIT: stay while tx_ready=1; -> IDLE on the first cycle tx_ready=0.
REQ-025 Write port: in any state except RD_ADDR, if wr_pend=1 and !full: drive ram_rw=0, ram_addr=wr_ptr, ram_wdata=pending byte; then wr_ptr+1, count+1, clear wr_pend.
REQ-026 Reads and writes SHALL never share a cycle, so count never increments and decrements on the same edge.
REQ-027 Latency: rx_rcv at edge N, in IDLE, empty buffer -> write at N+1; IDLE->RD_ADDR at N+2; tx_start asserted in cycle N+3.
REQ-028 Full with a pending write: handled per REQ-036/REQ-037.
REQ-029 If rx_rcv arrives while wr_pend=1, the block SHALL drop the new byte and set ovf.
REQ-030 Outside write cycles, ram_rw SHALL be 1 (never a spurious write); ram_addr=rd_ptr.
REQ-031 If clr coincides with rx_rcv, clr SHALL win and the byte SHALL be discarded.

Reset
REQ-032 rst asserted: state=IDLE; wr_ptr, rd_ptr, count=0; wr_pend=0; ovf=0; tx_start=0; tx_data=0; ram_rw=1; empty=1; full=0. Effect is immediate, without waiting for a clock edge.
REQ-033 If rst is asserted mid-operation (any state, pending write), the operation SHALL abort with no RAM write after assertion.
REQ-034 clr=1 on an edge SHALL produce the same register values as rst, synchronously; rst takes priority over clr.

Configuration
REQ-035 Macro RAMSCHED_OVERWRITE_EN selects full-buffer policy.
REQ-036 Undefined: pending write while full is dropped; wr_pend cleared; ovf set; pointers unchanged.
REQ-037 Defined: pending write while full overwrites the oldest byte at wr_ptr (==rd_ptr); wr_ptr and rd_ptr both +1; count stays 2^AW; ovf set.

Verification
REQ-038 Reset, then rx bytes 0x41,0x42,0x43 with tx_ready=1 -> tx_start pulses carry 0x41,0x42,0x43 in order; count returns to 0; ovf=0.
REQ-039 tx_ready=0, 16 bytes 0x00..0x0F (AW=4) -> full=1, count=16; 17th byte 0xAA -> ovf=1; release tx_ready -> without macro: 0x00..0x0F sent; with macro: 0x01..0x0F,0xAA sent.
REQ-040 Wrap: 20 bytes sent one at a time through the FIFO -> pointers wrap 15->0; output sequence equals input; never full.
REQ-041 tx_ready held high for 3 cycles after tx_start, then low -> exactly one tx_start per byte; no re-read before tx_ready returns to 1.
REQ-042 count=5, assert rst for 1 cycle during RD_ADDR -> immediately count=0, empty=1, state=IDLE; no tx_start follows.
REQ-043 clr coincident with rx_rcv (byte 0x55) -> count=0; 0x55 never written; ovf=0.

Source files
------------

// File: rtl/ram_buf_sched.sv
// ram_buf_sched: UART receive-to-transmit byte buffer that schedules a
// single-port synchronous RAM as a circular FIFO.
// Received bytes land in a one-entry pending register, are written to the RAM
// when the port is free, and are read back and handed to the transmitter when
// it is idle.
// tx_start is high for the single RD_DATA cycle. tx_data is registered at the
// end of that cycle, so it holds the byte from the following cycle onward.
// Optional build macro RAMSCHED_OVERWRITE_EN: when defined, a pending byte
// arriving at a full buffer overwrites the oldest stored byte instead of
// being dropped.
module ram_buf_sched #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          rx_rcv,
  input  logic [DW-1:0] rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, TX_WAIT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_pend;
  logic [DW-1:0] pend_data;
  logic          rd_en;
  logic          wr_service;
  logic          wr_en;
  logic          wr_drop;
  logic          wr_ovr;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // The write port is offered a slot whenever the RAM is not busy presenting
  // a read address; clr suppresses it so a clearing cycle never writes.
  assign wr_service = wr_pend && !clr && (state != RD_ADDR);

`ifdef RAMSCHED_OVERWRITE_EN
  assign wr_en   = wr_service;
  assign wr_drop = 1'b0;
  assign wr_ovr  = wr_service && full;
`else
  assign wr_en   = wr_service && !full;
  assign wr_drop = wr_service && full;
  assign wr_ovr  = 1'b0;
`endif

  // RAM port: read mode and read pointer unless a write is being issued
  assign ram_rw    = !wr_en;
  assign ram_addr  = wr_en ? wr_ptr : rd_ptr;
  assign ram_wdata = pend_data;

  // Next-state and read-side strobes for the transmit scheduler
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready && !wr_pend) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        rd_en     = 1'b1;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        tx_start  = 1'b1;
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, pointers, occupancy, pending flag, overflow, tx_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_pend <= 1'b0;
      ovf     <= 1'b0;
      tx_data <= '0;
    end else if (clr) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_pend <= 1'b0;
      ovf     <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      // Reads and writes are mutually exclusive by construction (no write in
      // RD_ADDR), so count never moves both ways on one edge.
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ovr) rd_ptr <= rd_ptr + 1'b1;
        else        count  <= count + 1'b1;
      end
      if (state == RD_DATA) tx_data <= ram_rdata;
      if ((rx_rcv && wr_pend) || wr_drop || wr_ovr) ovf <= 1'b1;
      if (rx_rcv && !wr_pend)     wr_pend <= 1'b1;
      else if (wr_en || wr_drop)  wr_pend <= 1'b0;
    end
  end

  // Pending byte payload; only loaded when the pending slot accepts it
  always_ff @(posedge clk) begin
    if (rx_rcv && !wr_pend && !clr) pend_data <= rx_data;
  end

endmodule

// File: tb/tb_ram_buf_sched.sv
// tb_ram_buf_sched: directed bench for ram_buf_sched with a behavioural
// synchronous RAM and a simple UART transmitter model.
module tb_ram_buf_sched;

  logic       clk, rst, clr, rx_rcv, tx_ready, tx_start, ram_rw, full, empty, ovf;
  logic [7:0] rx_data, tx_data, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;
  logic [4:0] count;

  int n_checks = 0;
  int n_errors = 0;

  ram_buf_sched #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rx_rcv(rx_rcv), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one cycle after the address
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (!ram_rw) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // UART transmitter model: optional hold-high period, then busy period
  logic uart_en = 1'b0;
  int   hold_cfg = 0;
  int   busy_cfg = 3;
  initial begin
    int h, b;
    h = 0; b = 0; tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!uart_en) begin
        tx_ready = 1'b0; h = 0; b = 0;
      end else if (h > 0) begin
        h--;
        if (h == 0) begin tx_ready = 1'b0; b = busy_cfg; end
      end else if (b > 0) begin
        b--;
        if (b == 0) tx_ready = 1'b1;
      end else if (tx_start) begin
        if (hold_cfg > 0) h = hold_cfg;
        else begin tx_ready = 1'b0; b = busy_cfg; end
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Output monitor: transmitted bytes, tx_start pulses, RAM write addresses
  logic [7:0] tx_q[$];
  logic [3:0] wr_addr_q[$];
  int   tx_cnt = 0;
  int   double_cnt = 0;
  logic track_full = 1'b0;
  logic full_seen = 1'b0;
  initial begin
    logic cap_next, prev_start;
    cap_next = 1'b0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (cap_next) tx_q.push_back(tx_data);
      if (tx_start) tx_cnt++;
      if (tx_start && prev_start) double_cnt++;
      if (ram_rw === 1'b0) wr_addr_q.push_back(ram_addr);
      if (track_full && full) full_seen = 1'b1;
      cap_next   = tx_start;
      prev_start = tx_start;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one edge, then leave room for the pending write
  task automatic rx_send(input logic [7:0] b);
    rx_rcv = 1'b1; rx_data = b;
    @(posedge clk); #1 rx_rcv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    int t0, w0;
    rst = 1'b0; clr = 1'b0; rx_rcv = 1'b0; rx_data = 8'h00;

    // Asynchronous reset state, observed before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ram_rw", ram_rw, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; uart_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Latency of the first byte into an empty, idle buffer
    rx_rcv = 1'b1; rx_data = 8'h41;
    @(posedge clk); #1 rx_rcv = 1'b0;
    check("lat_wr_rw", ram_rw, 0);
    check("lat_wr_addr", ram_addr, 0);
    check("lat_wr_data", ram_wdata, 8'h41);
    @(posedge clk); #1;
    check("lat_count1", count, 1);
    check("lat_rw_idle", ram_rw, 1);
    @(posedge clk); #1;
    check("lat_rdaddr_start", tx_start, 0);
    check("lat_rdaddr_addr", ram_addr, 0);
    @(posedge clk); #1;
    check("lat_tx_start", tx_start, 1);
    check("lat_count0", count, 0);

    // Three bytes in order
    rx_send(8'h42);
    rx_send(8'h43);
    wait_tx(3, 200);
    check("seq_n", tx_q.size(), 3);
    check("seq_b0", tx_q[0], 8'h41);
    check("seq_b1", tx_q[1], 8'h42);
    check("seq_b2", tx_q[2], 8'h43);
    check("seq_count", count, 0);
    check("seq_ovf", ovf, 0);
    check("seq_double", double_cnt, 0);

    // Fill to full with transmitter idle-off, then one byte too many
    uart_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rx_send(8'(i));
    check("full_flag", full, 1);
    check("full_count", count, 16);
    check("full_ovf0", ovf, 0);
    rx_send(8'hAA);
    check("ovf_flag", ovf, 1);
    check("ovf_count", count, 16);
    tx_q.delete();
    uart_en = 1'b1;
    wait_tx(16, 600);
    check("drain_n", tx_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
`ifdef RAMSCHED_OVERWRITE_EN
      exp_b = (i == 15) ? 8'hAA : 8'(i + 1);
`else
      exp_b = 8'(i);
`endif
      check($sformatf("drain_b%0d", i), tx_q[i], exp_b);
    end
    repeat (10) @(posedge clk);
    #1;
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("ovf_sticky", ovf, 1);
    pulse_clr();
    check("clr_ovf", ovf, 0);
    check("clr_count", count, 0);

    // Twenty bytes one at a time: pointers wrap, never full
    repeat (4) @(posedge clk);
    #1;
    tx_q.delete(); wr_addr_q.delete();
    track_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_send(8'(8'h80 + i));
      wait_tx(i + 1, 60);
    end
    track_full = 1'b0;
    check("wrap_n", tx_q.size(), 20);
    for (int i = 0; i < 20; i++) check($sformatf("wrap_b%0d", i), tx_q[i], 8'(8'h80 + i));
    check("wrap_nwr", wr_addr_q.size(), 20);
    check("wrap_addr15", wr_addr_q[15], 15);
    check("wrap_addr16", wr_addr_q[16], 0);
    check("wrap_full", full_seen, 0);

    // tx_ready held high three cycles after each tx_start
    uart_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx_send(8'h11); rx_send(8'h22); rx_send(8'h33);
    tx_q.delete();
    t0 = tx_cnt;
    hold_cfg = 3;
    uart_en = 1'b1;
    wait_tx(3, 200);
    repeat (20) @(posedge clk);
    #1;
    check("hold_starts", tx_cnt - t0, 3);
    check("hold_b0", tx_q[0], 8'h11);
    check("hold_b1", tx_q[1], 8'h22);
    check("hold_b2", tx_q[2], 8'h33);
    check("hold_double", double_cnt, 0);
    hold_cfg = 0;

    // Reset asserted while in RD_ADDR with five bytes stored
    uart_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) rx_send(8'(8'hC0 + i));
    check("rst5_count", count, 5);
    uart_en = 1'b1;
    @(posedge clk); #1;
    check("rst5_rdaddr", ram_addr, 7);
    rst = 1'b1;
    #1;
    check("rst5_count0", count, 0);
    check("rst5_empty", empty, 1);
    check("rst5_rw", ram_rw, 1);
    @(posedge clk); #1 rst = 1'b0;
    t0 = tx_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("rst5_no_tx", tx_cnt - t0, 0);
    check("rst5_count_after", count, 0);

    // clr coincident with a received byte
    uart_en = 1'b0;
    rx_send(8'h66); rx_send(8'h77);
    check("clrrx_pre", count, 2);
    w0 = wr_addr_q.size();
    rx_rcv = 1'b1; rx_data = 8'h55; clr = 1'b1;
    @(posedge clk); #1 rx_rcv = 1'b0; clr = 1'b0;
    check("clrrx_count", count, 0);
    check("clrrx_empty", empty, 1);
    check("clrrx_ovf", ovf, 0);
    repeat (5) @(posedge clk);
    #1;
    check("clrrx_no_wr", wr_addr_q.size() - w0, 0);
    t0 = tx_cnt;
    uart_en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("clrrx_no_tx", tx_cnt - t0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
